// File: rtl/slice_add_sequencer.sv
// Multi-cycle wide adder: one SLICE-bit carry-increment adder is stepped LSB-first
// across WIDTH/SLICE slices, with the inter-slice carry held in a register.

module carry_increment_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  localparam int NB = W / 4;

  logic [NB:0] c;
  assign c[0]   = cin_i;
  assign cout_o = c[NB];

  // Each nibble adds assuming no carry-in, then increments once the real carry arrives.
  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [4:0] raw;
    assign raw              = {1'b0, a_i[4*g +: 4]} + {1'b0, b_i[4*g +: 4]};
    assign sum_o[4*g +: 4]  = raw[3:0] + {3'b000, c[g]};
    assign c[g+1]           = raw[4] | (c[g] & (&raw[3:0]));
  end
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding slice idx_q, one slice per clock
// DONE  | result held on sum/cout until out_ready
module slice_add_sequencer #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [SLICE-1:0]   slc_a, slc_b, slc_sum;
  logic               slc_cout;
  logic               accept;

  assign slc_a = op_a_q[idx_q*SLICE +: SLICE];
  assign slc_b = op_b_q[idx_q*SLICE +: SLICE];

  carry_increment_adder #(.W(SLICE)) u_slice (
    .a_i    (slc_a),
    .b_i    (slc_b),
    .cin_i  (carry_q),
    .sum_o  (slc_sum),
    .cout_o (slc_cout)
  );

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: ;
      RUN: begin
        sum_d[idx_q*SLICE +: SLICE] = slc_sum;
        carry_d = slc_cout;
        if (idx_q == LAST) begin
          cout_d  = slc_cout;
          state_d = DONE;
        end else begin
          idx_d = IDXW'(idx_q + 1'b1);
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Accepting from DONE skips IDLE so back-to-back transfers have no bubble.
    if (accept) begin
      op_a_d  = a;
      op_b_d  = b;
      carry_d = cin;
      idx_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule

// File: tb/tb_slice_add_sequencer.sv
// Directed bench for slice_add_sequencer: expected {cout,sum} values are queued at
// accept time and compared when the result handshake occurs.

module tb_slice_add_sequencer;
  localparam int WIDTH = 64;
  localparam int SLICE = 16;
  localparam int N     = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH:0] exp_q[$];
  time            out_t[$];

  always #5 clk = ~clk;

  slice_add_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  task automatic chk(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Result scoreboard: compare on every completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_t.push_back($time);
      if (exp_q.size() == 0) chk("unexpected_result", {cout, sum}, '1);
      else chk("result", {cout, sum}, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer operands from IDLE, scramble inputs during RUN, return cycles until out_valid.
  task automatic start_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic c, output int lat);
    a = x; b = y; cin = c; in_valid = 1'b1;
    chk("in_ready_idle", {64'd0, in_ready}, 65'd1);
    exp_q.push_back(model(x, y, c));
    step();
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic do_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    int lat;
    start_add(x, y, c, lat);
    chk("latency", 65'(lat), 65'(N));
    step();
    chk("idle_after", {63'd0, out_valid, busy}, 65'd0);
  endtask

  initial begin
    int lat;
    logic [WIDTH:0] held;
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
    repeat (3) step();
    chk("rst_flags", {62'd0, in_ready, out_valid, busy}, 65'b100);
    chk("rst_result", {cout, sum}, 65'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_after_rst", {62'd0, in_ready, out_valid, busy}, 65'b100);

    do_add(64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 1'b0);
    do_add(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    do_add(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    for (int i = 0; i < 4; i++)
      do_add({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    start_add(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, lat);
    held = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    chk("bp_latency", 65'(lat), 65'(N));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      chk("bp_hold", {cout, sum}, held);
      chk("bp_flags", {63'd0, in_ready, out_valid}, 65'b01);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release", {63'd0, out_valid, busy}, 65'd0);

    // Back-to-back with in_valid held high.
    out_t.delete();
    a = 64'd1; b = 64'd1; cin = 1'b0; in_valid = 1'b1;
    exp_q.push_back(65'd2);
    step();
    a = 64'd2; b = 64'd3; cin = 1'b1;
    exp_q.push_back(65'd6);
    repeat (N + 1) step();
    in_valid = 1'b0;
    chk("b2b_rerun", {64'd0, busy}, 65'd1);
    repeat (N + 6) step();
    chk("b2b_count", 65'(out_t.size()), 65'd2);
    if (out_t.size() == 2) chk("b2b_spacing", 65'(out_t[1] - out_t[0]), 65'((N + 1) * 10));
    chk("b2b_drained", 65'(exp_q.size()), 65'd0);

    // Reset during the second RUN cycle discards the transaction.
    a = 64'hAAAA; b = 64'h5555; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_flags", {62'd0, in_ready, out_valid, busy}, 65'b100);
    chk("midrst_result", {cout, sum}, 65'd0);
    step();
    rst_n = 1'b1;
    step();
    do_add(64'd5, 64'd7, 1'b0);
    chk("final_drained", 65'(exp_q.size()), 65'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
